// File: rtl/updi_target_responder.sv
// UPDI target-side instruction engine: SYNC/opcode parsing, LDS/STS data-space access, LDCS/STCS CS file.
// Optional feature: define UPDI_TARGET_GUARD_TIME_EN to hold off the first response byte by GUARD_CYCLES.
module updi_target_responder #(
  parameter int unsigned ADDR_BITS     = 16,
  parameter logic [7:0]  STATUSA_RESET = 8'h30,
  parameter int unsigned GUARD_CYCLES  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic                 rx_break,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 mem_we,
  output logic                 mem_re,
  input  logic [7:0]           mem_rdata,
  output logic                 protocol_error
);

  typedef enum logic [3:0] {
    WAIT_SYNC, OPCODE, ADDR, STS_ACK1, STS_DATA, STS_ACK2,
    LDS_READ, LDS_SEND, LDCS_SEND, STCS_DATA
  } state_t;

  localparam logic [7:0] SYNC_BYTE   = 8'h55;
  localparam logic [7:0] ACK_BYTE    = 8'h40;
  localparam logic [2:0] ERR_ILLEGAL = 3'd4;

  state_t                 state_q, state_d;
  logic                   is_lds_q;
  logic                   size_a_q;
  logic                   size_b_q;
  logic                   idx_q;
  logic                   addr_hi_q;
  logic [3:0]             cs_addr_q;
  logic [ADDR_BITS-1:0]   base_q;
  logic [1:0]             rd_phase_q;
  logic [7:0]             cs_q [16];

  logic                   rx_ready_q;
  logic                   tx_valid_q;
  logic [7:0]             tx_data_q;
  logic [ADDR_BITS-1:0]   mem_addr_q;
  logic [7:0]             mem_wdata_q;
  logic                   mem_we_q;
  logic                   mem_re_q;
  logic                   protocol_error_q;

  logic                   rx_fire_c;
  logic                   tx_fire_c;
  logic                   op_lds_c, op_sts_c, op_ldcs_c, op_stcs_c, op_illegal_c;
  logic                   size_bad_c;
  logic                   addr_last_c;
  logic [ADDR_BITS-1:0]   cur_addr_c;
  logic                   guard_done_c;

`ifdef UPDI_TARGET_GUARD_TIME_EN
  localparam int unsigned GUARD_W      = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic        FIRST_TX_NOW = 1'b0;
  logic [GUARD_W-1:0]     guard_q;
  logic                   guard_load_c;

  assign guard_done_c = (guard_q == '0);
  assign guard_load_c = ((state_q == OPCODE) && (state_d == LDCS_SEND)) ||
                        ((state_q == ADDR) && (state_d inside {STS_ACK1, LDS_READ}));

  // Counts down the idle gap between the last received byte and the first response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      guard_q <= '0;
    end else if (guard_load_c) begin
      guard_q <= GUARD_W'(GUARD_CYCLES - 1);
    end else if (!guard_done_c) begin
      guard_q <= guard_q - GUARD_W'(1);
    end
  end
`else
  localparam logic        FIRST_TX_NOW = 1'b1;
  logic                   guard_unused;

  assign guard_done_c = 1'b1;
  assign guard_unused = (GUARD_CYCLES == 0);
`endif

  assign rx_fire_c    = rx_valid && rx_ready_q;
  assign tx_fire_c    = tx_valid_q && tx_ready;
  assign op_lds_c     = (rx_data[7:5] == 3'b000);
  assign op_sts_c     = (rx_data[7:5] == 3'b010);
  assign op_ldcs_c    = (rx_data[7:5] == 3'b100);
  assign op_stcs_c    = (rx_data[7:5] == 3'b110);
  assign size_bad_c   = rx_data[3] | rx_data[1];
  assign op_illegal_c = !(((op_lds_c || op_sts_c) && !size_bad_c) || op_ldcs_c || op_stcs_c);
  assign addr_last_c  = addr_hi_q || !size_a_q;
  assign cur_addr_c   = base_q + ADDR_BITS'(idx_q);

  // Next-state decode; BREAK overrides everything.
  always_comb begin
    state_d = state_q;
    if (rx_break) begin
      state_d = WAIT_SYNC;
    end else begin
      case (state_q)
        WAIT_SYNC: if (rx_fire_c && (rx_data == SYNC_BYTE)) state_d = OPCODE;
        OPCODE: begin
          if (rx_fire_c) begin
            if (op_illegal_c)                state_d = WAIT_SYNC;
            else if (op_lds_c || op_sts_c)   state_d = ADDR;
            else if (op_ldcs_c)              state_d = LDCS_SEND;
            else                             state_d = STCS_DATA;
          end
        end
        ADDR:      if (rx_fire_c && addr_last_c) state_d = is_lds_q ? LDS_READ : STS_ACK1;
        STS_ACK1:  if (tx_fire_c) state_d = STS_DATA;
        STS_DATA:  if (rx_fire_c && (idx_q == size_b_q)) state_d = STS_ACK2;
        STS_ACK2:  if (tx_fire_c) state_d = WAIT_SYNC;
        LDS_READ:  if (rd_phase_q == 2'd2) state_d = LDS_SEND;
        LDS_SEND:  if (tx_fire_c) state_d = (idx_q == size_b_q) ? WAIT_SYNC : LDS_READ;
        LDCS_SEND: if (tx_fire_c) state_d = WAIT_SYNC;
        STCS_DATA: if (rx_fire_c) state_d = WAIT_SYNC;
        default:   state_d = WAIT_SYNC;
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= WAIT_SYNC;
      is_lds_q         <= 1'b0;
      size_a_q         <= 1'b0;
      size_b_q         <= 1'b0;
      idx_q            <= 1'b0;
      addr_hi_q        <= 1'b0;
      cs_addr_q        <= 4'd0;
      base_q           <= '0;
      rd_phase_q       <= 2'd0;
      rx_ready_q       <= 1'b0;
      tx_valid_q       <= 1'b0;
      tx_data_q        <= 8'h00;
      mem_addr_q       <= '0;
      mem_wdata_q      <= 8'h00;
      mem_we_q         <= 1'b0;
      mem_re_q         <= 1'b0;
      protocol_error_q <= 1'b0;
      cs_q[0]          <= STATUSA_RESET;
      for (int i = 1; i < 16; i++) cs_q[i] <= 8'h00;
    end else begin
      state_q          <= state_d;
      rx_ready_q       <= (state_d inside {WAIT_SYNC, OPCODE, ADDR, STS_DATA, STCS_DATA});
      mem_we_q         <= 1'b0;
      mem_re_q         <= 1'b0;
      protocol_error_q <= 1'b0;
      if (rx_break) begin
        tx_valid_q <= 1'b0;
        rd_phase_q <= 2'd0;
      end else begin
        case (state_q)
          OPCODE: begin
            if (rx_fire_c) begin
              is_lds_q  <= op_lds_c;
              size_a_q  <= rx_data[2];
              size_b_q  <= rx_data[0];
              cs_addr_q <= rx_data[3:0];
              idx_q     <= 1'b0;
              addr_hi_q <= 1'b0;
              if (op_illegal_c) begin
                protocol_error_q <= 1'b1;
                cs_q[1][2:0]     <= ERR_ILLEGAL;
              end else if (op_ldcs_c) begin
                tx_data_q  <= cs_q[rx_data[3:0]];
                tx_valid_q <= FIRST_TX_NOW;
              end
            end
          end
          ADDR: begin
            if (rx_fire_c) begin
              if (!addr_hi_q) begin
                base_q    <= ADDR_BITS'(rx_data);
                addr_hi_q <= 1'b1;
              end else begin
                base_q <= ADDR_BITS'({rx_data, base_q[7:0]});
              end
              if (addr_last_c && !is_lds_q) begin
                tx_data_q  <= ACK_BYTE;
                tx_valid_q <= FIRST_TX_NOW;
              end
            end
          end
          STS_ACK1, LDCS_SEND: begin
            if (tx_fire_c)         tx_valid_q <= 1'b0;
            else if (guard_done_c) tx_valid_q <= 1'b1;
          end
          STS_DATA: begin
            if (rx_fire_c) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= cur_addr_c;
              mem_wdata_q <= rx_data;
              if (idx_q == size_b_q) begin
                tx_data_q  <= ACK_BYTE;
                tx_valid_q <= 1'b1;
              end else begin
                idx_q <= 1'b1;
              end
            end
          end
          STS_ACK2: if (tx_fire_c) tx_valid_q <= 1'b0;
          // Strobe, wait one cycle for read data, then capture it.
          LDS_READ: begin
            case (rd_phase_q)
              2'd0: begin
                if (guard_done_c) begin
                  mem_re_q   <= 1'b1;
                  mem_addr_q <= cur_addr_c;
                  rd_phase_q <= 2'd1;
                end
              end
              2'd1: rd_phase_q <= 2'd2;
              default: begin
                tx_data_q  <= mem_rdata;
                tx_valid_q <= 1'b1;
                rd_phase_q <= 2'd0;
              end
            endcase
          end
          LDS_SEND: begin
            if (tx_fire_c) begin
              tx_valid_q <= 1'b0;
              idx_q      <= 1'b1;
            end
          end
          STCS_DATA: begin
            if (rx_fire_c && (cs_addr_q != 4'd0)) cs_q[cs_addr_q] <= rx_data;
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_ready       = rx_ready_q;
  assign tx_valid       = tx_valid_q;
  assign tx_data        = tx_data_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign mem_we         = mem_we_q;
  assign mem_re         = mem_re_q;
  assign protocol_error = protocol_error_q;

endmodule

// File: tb/tb_updi_target_responder.sv
// Bench for updi_target_responder: vector table plus scoreboards for tx bytes and memory strobes.
module tb_updi_target_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        rx_break = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata = 8'h00;
  logic        protocol_error;

  updi_target_responder dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_break(rx_break),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nrx;
    logic [47:0] rx;
    int          ntx;
    logic [23:0] tx;
    int          nmem;
    logic [1:0]  mw;
    logic [31:0] ma;
    logic [15:0] md;
    int          perr;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [15:0] a;
    logic [7:0]  d;
  } mev_t;

  logic [7:0] tx_q [$];
  mev_t       mem_q [$];
  int         errors = 0;
  int         checks = 0;
  int         perr_seen = 0;
  logic       stall = 1'b0;
  vec_t       vecs [17];

  function automatic logic [7:0] mem_model(input logic [15:0] a);
    if (a == 16'hFFFF) return 8'h11;
    if (a == 16'h0000) return 8'h22;
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic vec_t mkv(input int nrx, input logic [47:0] rx, input int ntx,
                               input logic [23:0] tx, input int nmem, input logic [1:0] mw,
                               input logic [31:0] ma, input logic [15:0] md, input int perr);
    vec_t v;
    v.nrx = nrx; v.rx = rx; v.ntx = ntx; v.tx = tx; v.nmem = nmem;
    v.mw = mw; v.ma = ma; v.md = md; v.perr = perr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_to(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Read data appears exactly one cycle after the strobe.
  always @(posedge clk) if (mem_re) mem_rdata <= mem_model(mem_addr);

  initial forever begin
    @(posedge clk);
    #1;
    tx_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Output monitor: scoreboards, hold stability, strobe exclusivity.
  initial begin
    logic       hold_v;
    logic [7:0] hold_d;
    logic [7:0] exp_b;
    mev_t       m;
    hold_v = 1'b0;
    hold_d = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected actual=%h required=none", tx_data);
        end else begin
          exp_b = tx_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(exp_b));
        end
      end
      if (hold_v && tx_valid) check("tx_hold", 32'(tx_data), 32'(hold_d));
      hold_v = tx_valid && !tx_ready;
      hold_d = tx_data;
      if (mem_we || mem_re) begin
        check("we_re_excl", 32'(mem_we & mem_re), 32'd0);
        if (mem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_unexpected actual=we%0d re%0d addr=%h required=none", mem_we, mem_re, mem_addr);
        end else begin
          m = mem_q.pop_front();
          check("mem_kind", 32'(mem_we), 32'(m.we));
          check("mem_addr", 32'(mem_addr), 32'(m.a));
          if (mem_we) check("mem_wdata", 32'(mem_wdata), 32'(m.d));
        end
      end
      if (protocol_error) perr_seen++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail_to("rx_ready_wait");
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((tx_q.size() != 0 || mem_q.size() != 0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) fail_to("drain");
  endtask

  task automatic pulse_break();
    rx_break = 1'b1;
    @(negedge clk);
    rx_break = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int p0;
    mev_t m;
    p0 = perr_seen;
    for (int i = 0; i < v.ntx; i++) tx_q.push_back(v.tx[8*i +: 8]);
    for (int i = 0; i < v.nmem; i++) begin
      m.we = v.mw[i];
      m.a  = v.ma[16*i +: 16];
      m.d  = v.md[8*i +: 8];
      mem_q.push_back(m);
    end
    for (int i = 0; i < v.nrx; i++) send_byte(v.rx[8*i +: 8]);
    drain();
    repeat (3) @(negedge clk);
    check("perr_count", 32'(perr_seen - p0), 32'(v.perr));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=hang required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k;
    mev_t m;
    vecs[0]  = mkv(2, 48'h80_55,             1, 24'h30,    0, 2'b00, 32'h0,         16'h0,    0);
    vecs[1]  = mkv(5, 48'hAB_10_00_44_55,    2, 24'h40_40, 1, 2'b01, 32'h0000_1000, 16'h00AB, 0);
    vecs[2]  = mkv(4, 48'hFF_FF_05_55,       2, 24'h22_11, 2, 2'b00, 32'h0000_FFFF, 16'h0,    0);
    vecs[3]  = mkv(2, 48'h20_55,             0, 24'h0,     0, 2'b00, 32'h0,         16'h0,    1);
    vecs[4]  = mkv(2, 48'h81_55,             1, 24'h04,    0, 2'b00, 32'h0,         16'h0,    0);
    vecs[5]  = mkv(3, 48'h5A_C2_55,          0, 24'h0,     0, 2'b00, 32'h0,         16'h0,    0);
    vecs[6]  = mkv(2, 48'h82_55,             1, 24'h5A,    0, 2'b00, 32'h0,         16'h0,    0);
    vecs[7]  = mkv(3, 48'h99_C0_55,          0, 24'h0,     0, 2'b00, 32'h0,         16'h0,    0);
    vecs[8]  = mkv(2, 48'h80_55,             1, 24'h30,    0, 2'b00, 32'h0,         16'h0,    0);
    vecs[9]  = mkv(3, 48'h00_C1_55,          0, 24'h0,     0, 2'b00, 32'h0,         16'h0,    0);
    vecs[10] = mkv(2, 48'h81_55,             1, 24'h00,    0, 2'b00, 32'h0,         16'h0,    0);
    vecs[11] = mkv(3, 48'h80_55_12,          1, 24'h30,    0, 2'b00, 32'h0,         16'h0,    0);
    vecs[12] = mkv(6, 48'h02_01_FF_FF_45_55, 2, 24'h40_40, 2, 2'b11, 32'h0000_FFFF, 16'h0201, 0);
    vecs[13] = mkv(3, 48'h34_00_55,          1, 24'h91,    1, 2'b00, 32'h0000_0034, 16'h0,    0);
    vecs[14] = mkv(2, 48'h0A_55,             0, 24'h0,     0, 2'b00, 32'h0,         16'h0,    1);
    vecs[15] = mkv(2, 48'hE0_55,             0, 24'h0,     0, 2'b00, 32'h0,         16'h0,    1);
    vecs[16] = mkv(2, 48'h81_55,             1, 24'h04,    0, 2'b00, 32'h0,         16'h0,    0);

    repeat (3) @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_perr", 32'(protocol_error), 32'd0);
    rst = 1'b1;
    #1;
    check("rx_ready_pre_clk", 32'(rx_ready), 32'd0);
    @(negedge clk);
    check("rx_ready_post_clk", 32'(rx_ready), 32'd1);

    for (int i = 0; i < 17; i++) run_vec(vecs[i]);

    // BREAK after the STS address ACK: the pending data write must never happen.
    tx_q.push_back(8'h40);
    send_byte(8'h55); send_byte(8'h40); send_byte(8'h00);
    drain();
    pulse_break();
    repeat (3) @(negedge clk);
    run_vec(vecs[0]);

    // BREAK while an LDS response is stalled: tx_valid must drop.
    stall = 1'b1;
    m.we = 1'b0; m.a = 16'h0010; m.d = 8'h00;
    mem_q.push_back(m);
    send_byte(8'h55); send_byte(8'h00); send_byte(8'h10);
    k = 0;
    while (!tx_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) fail_to("lds_tx_valid");
    check("lds_stalled_data", 32'(tx_data), 32'h0000_00B5);
    check("lds_read_seen", 32'(mem_q.size()), 32'd0);
    pulse_break();
    check("break_tx_valid", 32'(tx_valid), 32'd0);
    check("break_rx_ready", 32'(rx_ready), 32'd1);
    stall = 1'b0;
    repeat (3) @(negedge clk);
    run_vec(vecs[0]);

    // Reset in the middle of an STS: no write afterwards, CS[1] cleared.
    tx_q.push_back(8'h40);
    send_byte(8'h55); send_byte(8'h40); send_byte(8'h05);
    drain();
    rst = 1'b0;
    #1;
    check("midrst_rx_ready", 32'(rx_ready), 32'd0);
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_vec(vecs[10]);
    run_vec(vecs[0]);

`ifdef UPDI_TARGET_GUARD_TIME_EN
    tx_q.push_back(8'h30);
    send_byte(8'h55); send_byte(8'h80);
    k = 0;
    while (!tx_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("guard_cycles", 32'(k), 32'd16);
    drain();
`endif

    repeat (5) @(negedge clk);
    check("tx_q_empty", 32'(tx_q.size()), 32'd0);
    check("mem_q_empty", 32'(mem_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updi_target_responder.md
UPDI_TARGET_RESPONDER -- requirements
Module: updi_target_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 16, width of mem_addr.
REQ-002 SHALL have parameter STATUSA_RESET, default 8'h30, reset value of CS register 0.
REQ-003 SHALL have parameter GUARD_CYCLES, default 16, idle cycles inserted before a response when guard time is enabled.
REQ-004 SHALL have ports:
- clk, input, 1: single clock; all logic on rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- rx_data, input, 8: received UPDI byte.
- rx_valid, input, 1: rx_data valid.
- rx_ready, output, 1: responder accepts the byte this cycle.
- rx_break, input, 1: one-cycle pulse on a detected BREAK.
- tx_data, output, 8: response byte.
- tx_valid, output, 1: tx_data valid.
- tx_ready, input, 1: consumer takes tx_data this cycle.
- mem_addr, output, ADDR_BITS: data-space address.
- mem_wdata, output, 8: write data.
- mem_we, output, 1: one-cycle write strobe.
- mem_re, output, 1: one-cycle read strobe.
- mem_rdata, input, 8: read data, valid exactly one cycle after mem_re.
- protocol_error, output, 1: one-cycle pulse on an unsupported or illegal instruction.

Function
REQ-005 A byte SHALL transfer on rx_valid && rx_ready; a byte SHALL leave on tx_valid && tx_ready; tx_valid and tx_data SHALL be held stable until accepted.
REQ-006 State machine states: WAIT_SYNC, OPCODE, ADDR, STS_ACK1, STS_DATA, STS_ACK2, LDS_READ, LDS_SEND, LDCS_SEND, STCS_DATA.
REQ-007 WAIT_SYNC: rx_ready=1. Byte 8'h55 SHALL go to OPCODE. Any other byte SHALL be discarded silently.
REQ-008 OPCODE: bits[7:5] decode the instruction.
- 3'b000 = LDS; 3'b010 = STS. Both carry size_a=bits[3:2] and size_b=bits[1:0].
- 3'b100 = LDCS; 3'b110 = STCS. Both carry cs_addr=bits[3:0].
- Any other opcode, or size_a>1, or size_b>1, is illegal.
REQ-009 Illegal instruction SHALL:
- pulse protocol_error;
- write CS[1][2:0]=3'd4 (sticky until STCS or reset);
- send nothing;
- return to WAIT_SYNC.
REQ-010 ADDR: receives 1 byte (size_a=0, zero-extended) or 2 bytes little-endian (size_a=1).
REQ-011 STS:
- after the address, SHALL send ACK 8'h40 (STS_ACK1);
- SHALL receive 1 or 2 data bytes (size_b);
- each data byte SHALL produce mem_we with mem_addr=base+index, the cycle after it is received;
- after the last byte, SHALL send ACK 8'h40 (STS_ACK2), then return to WAIT_SYNC.
REQ-012 LDS:
- per data byte, SHALL pulse mem_re at base+index;
- SHALL capture mem_rdata the next cycle and send it (LDS_SEND);
- the next mem_re SHALL issue only after the previous byte is accepted;
- then WAIT_SYNC.
REQ-013 Address increment SHALL wrap modulo 2^ADDR_BITS.
REQ-014 LDCS SHALL send CS[cs_addr], then go to WAIT_SYNC.
REQ-015 STCS SHALL receive one byte, write CS[cs_addr], send no ACK, then go to WAIT_SYNC. STCS to cs_addr 0 SHALL be ignored (read-only).
REQ-016 CS file: 16 x 8 registers, internal.
REQ-017 rx_ready SHALL be 1 only in WAIT_SYNC, OPCODE, ADDR, STS_DATA, STCS_DATA. tx_valid SHALL be 1 only in STS_ACK1, STS_ACK2, LDS_SEND, LDCS_SEND.
REQ-018 rx_break SHALL take priority over all other events. In any state, the next state SHALL be WAIT_SYNC, with:
- tx_valid dropped;
- no mem_we/mem_re issued that cycle or after;
- CS contents kept.
REQ-019 mem_we and mem_re SHALL never be asserted in the same cycle.

Reset
REQ-020 On rst low, asynchronously:
- state=WAIT_SYNC;
- rx_ready=0 until the first clock after release;
- tx_valid=0, tx_data=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, protocol_error=0;
- CS[0]=STATUSA_RESET; CS[1..15]=0.
REQ-021 Reset mid-transaction SHALL abandon it with no further memory strobes.

Configuration
REQ-022 Macro UPDI_TARGET_GUARD_TIME_EN:
- defined: before the first response byte of an instruction, tx_valid SHALL stay 0 for GUARD_CYCLES cycles after the last received byte;
- undefined: tx_valid SHALL assert the cycle after the response is ready, and GUARD_CYCLES SHALL be unused.

Verification
REQ-023 Reset, then rx 55,80 -> tx 30, then WAIT_SYNC.
REQ-024 rx 55,44,00,10 -> tx 40; rx AB -> mem_we addr 0x1000 wdata AB; tx 40.
REQ-025 rx 55,05,FF,FF, with mem returning 11 then 22 -> mem_re at 0xFFFF then 0x0000 (wrap); tx 11, 22.
REQ-026 rx 55,20 -> no tx, protocol_error pulse; rx 55,81 -> tx 04.
REQ-027 rx 55,40,00, tx 40 accepted, then rx_break -> no mem_we; rx 55,80 -> tx 30.
REQ-028 With UPDI_TARGET_GUARD_TIME_EN, rx 55,80 -> tx_valid rises exactly 16 cycles after the 80 byte is accepted.
